// File: rtl/keysched_ctrl_if.sv
// Host-side bus of the Twofish key-schedule controller: schedule request,
// status flags and the random-access subkey read port.
interface keysched_ctrl_if #(
  parameter int AW = 6
);
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         err;
  logic         keys_valid;
  logic [AW-1:0] rd_addr;
  logic [31:0]  rd_data;

  // start is a request without a ready: it is taken only while busy==0 and
  // dropped otherwise; done/err report the outcome of the accepted request.
  modport master (
    output start, key_in, rd_addr,
    input  busy, done, err, keys_valid, rd_data
  );

  modport slave (
    input  start, key_in, rd_addr,
    output busy, done, err, keys_valid, rd_data
  );
endinterface

// File: rtl/keysched_ctrl.sv
// Sequencer for the Twofish subkey generator: restarts skeygen on a new key,
// steps it once per pair and captures the pairs into a readable subkey file.
module keysched_ctrl #(
  parameter int NPAIRS     = 20,
  parameter int AW         = 6,
  parameter int CHECK_ZERO = 1
) (
  input  logic           clk,
  input  logic           reset,
  keysched_ctrl_if.slave host,
  output logic [127:0]   sg_key,
  output logic           sg_reset,
  output logic           sg_ce,
  input  logic [31:0]    sg_keys0,
  input  logic [31:0]    sg_keys1,
  input  logic           sg_zero,
  output logic [2:0]     state_dbg
);

  localparam int CW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam logic [CW-1:0] LAST   = CW'(NPAIRS - 1);
  localparam logic [AW:0]   NWORDS = (AW + 1)'(2 * NPAIRS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WAIT  = 3'd2,
    S_RUN   = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [127:0]  key_reg;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          valid_r;
  logic [31:0]   rd_data_r;

  // One entry per pair: {odd subkey, even subkey}, so a capture is one write.
  logic [63:0]   pair_mem [NPAIRS];
  logic [AW-2:0] rd_pair;

  assign sg_key    = key_reg;
  assign sg_reset  = reset | (state == S_INIT);
  assign sg_ce     = (state == S_RUN) & ~sg_zero;
  assign state_dbg = state;

  assign host.busy       = busy_r;
  assign host.done       = done_r;
  assign host.err        = err_r;
  assign host.keys_valid = valid_r;
  assign host.rd_data    = rd_data_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      key_reg <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (host.start) begin
            key_reg <= host.key_in;
            err_r   <= 1'b0;
            valid_r <= 1'b0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= S_INIT;
          end
        end
        S_INIT: state <= S_WAIT;
        S_WAIT: state <= S_RUN;
        S_RUN: begin
          // Generator ran dry before the last pair: the schedule is unusable.
          if (sg_zero) begin
            err_r  <= 1'b1;
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (CHECK_ZERO == 0 || sg_zero) begin
            done_r  <= 1'b1;
            valid_r <= 1'b1;
          end else begin
            err_r <= 1'b1;
          end
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Subkey file is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (sg_ce && !reset) pair_mem[cnt] <= {sg_keys1, sg_keys0};
  end

  assign rd_pair = host.rd_addr[AW-1:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= '0;
    end else if ({1'b0, host.rd_addr} < NWORDS) begin
      rd_data_r <= host.rd_addr[0] ? pair_mem[rd_pair][63:32] : pair_mem[rd_pair][31:0];
    end else begin
      rd_data_r <= '0;
    end
  end

endmodule

// File: tb/tb_keysched_ctrl.sv
// Bench for keysched_ctrl: two instances (zero check on / off) share one host
// stimulus; a behavioural skeygen and subkey-file model supply expectations.
module tb_keysched_ctrl;
  localparam int NPAIRS = 20;
  localparam int AW     = 6;
  localparam int NW     = 2 * NPAIRS;
  localparam logic [127:0] KEY_NOM = 128'h2b7e151628aed2a6abf7158809cf4f3d;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keysched_ctrl_if #(.AW(AW)) h0 ();
  keysched_ctrl_if #(.AW(AW)) h1 ();

  logic [127:0] sg_key   [2];
  logic         sg_reset [2];
  logic         sg_ce    [2];
  logic         sg_zero  [2];
  logic [31:0]  k0       [2];
  logic [31:0]  k1       [2];
  logic [2:0]   st       [2];

  keysched_ctrl #(.NPAIRS(NPAIRS), .AW(AW), .CHECK_ZERO(1)) dut0 (
    .clk(clk), .reset(reset), .host(h0),
    .sg_key(sg_key[0]), .sg_reset(sg_reset[0]), .sg_ce(sg_ce[0]),
    .sg_keys0(k0[0]), .sg_keys1(k1[0]), .sg_zero(sg_zero[0]), .state_dbg(st[0])
  );

  keysched_ctrl #(.NPAIRS(NPAIRS), .AW(AW), .CHECK_ZERO(0)) dut1 (
    .clk(clk), .reset(reset), .host(h1),
    .sg_key(sg_key[1]), .sg_reset(sg_reset[1]), .sg_ce(sg_ce[1]),
    .sg_keys0(k0[1]), .sg_keys1(k1[1]), .sg_zero(sg_zero[1]), .state_dbg(st[1])
  );

  // Skeygen model: pair i = {base+2i, base+2i+1}; zero once zero_at pairs were stepped.
  int          pos [2];
  int          zero_at = 20;
  logic [31:0] base = 32'h1000_0000;

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (sg_reset[m])   pos[m] <= 0;
      else if (sg_ce[m]) pos[m] <= pos[m] + 1;
    end
  end

  assign k0[0] = base + 32'(2 * pos[0]);
  assign k1[0] = base + 32'(2 * pos[0] + 1);
  assign k0[1] = base + 32'(2 * pos[1]);
  assign k1[1] = base + 32'(2 * pos[1] + 1);
  assign sg_zero[0] = (pos[0] >= zero_at);
  assign sg_zero[1] = (pos[1] >= zero_at);

  // Scoreboard
  logic [31:0] exp_mem [2][NW];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic drive_start(input logic s, input logic [127:0] k);
    h0.start = s; h1.start = s;
    h0.key_in = k; h1.key_in = k;
  endtask

  task automatic update_model(input int za, input logic [31:0] b);
    int np;
    np = (za < NPAIRS) ? za : NPAIRS;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 2 * np; i++) exp_mem[m][i] = b + 32'(i);
  endtask

  // Applies one schedule and checks its outcome; extra_k>0 re-pulses start so
  // that it is sampled at start edge + extra_k.
  task automatic run_sched(input int za, input logic [31:0] b, input logic [127:0] key,
                           input int extra_k, input logic [127:0] key2,
                           input logic [1:0] ex_done, input logic [1:0] ex_err, input int ex_ce,
                           input string tag);
    int ce_n [2];
    int done_n [2];
    int done_k [2];
    zero_at = za;
    base    = b;
    for (int m = 0; m < 2; m++) begin ce_n[m] = 0; done_n[m] = 0; done_k[m] = -1; end
    @(negedge clk);
    drive_start(1'b1, key);
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) drive_start(1'b0, key);
      if (extra_k > 0 && k == extra_k - 1) drive_start(1'b1, key2);
      if (extra_k > 0 && k == extra_k) drive_start(1'b0, key);
      if (k == 0) begin
        chk({tag, " busy0 m0"}, h0.busy, 1'b1);
        chk({tag, " busy0 m1"}, h1.busy, 1'b1);
      end
      if (sg_ce[0]) ce_n[0]++;
      if (sg_ce[1]) ce_n[1]++;
      if (h0.done) begin done_n[0]++; done_k[0] = k; end
      if (h1.done) begin done_n[1]++; done_k[1] = k; end
    end
    chk({tag, " done_n m0"}, done_n[0], ex_done[0] ? 1 : 0);
    chk({tag, " done_n m1"}, done_n[1], ex_done[1] ? 1 : 0);
    if (ex_done[0]) chk({tag, " done_at m0"}, done_k[0], NPAIRS + 3);
    if (ex_done[1]) chk({tag, " done_at m1"}, done_k[1], NPAIRS + 3);
    chk({tag, " err m0"}, h0.err, ex_err[0]);
    chk({tag, " err m1"}, h1.err, ex_err[1]);
    chk({tag, " valid m0"}, h0.keys_valid, ex_done[0]);
    chk({tag, " valid m1"}, h1.keys_valid, ex_done[1]);
    chk({tag, " ce_n m0"}, ce_n[0], ex_ce);
    chk({tag, " ce_n m1"}, ce_n[1], ex_ce);
    chk({tag, " busy_end m0"}, h0.busy, 1'b0);
    chk({tag, " busy_end m1"}, h1.busy, 1'b0);
    chk({tag, " sg_key m0"}, sg_key[0], key);
    chk({tag, " sg_key m1"}, sg_key[1], key);
    update_model(za, b);
  endtask

  task automatic read_word(input int a);
    logic [31:0] exp;
    @(negedge clk);
    h0.rd_addr = AW'(a);
    h1.rd_addr = AW'(a);
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back((a < NW) ? exp_mem[0][a] : 32'h0);
    exp_q.push_back((a < NW) ? exp_mem[1][a] : 32'h0);
    exp = exp_q.pop_front();
    chk($sformatf("rd[%0d] m0", a), h0.rd_data, exp);
    exp = exp_q.pop_front();
    chk($sformatf("rd[%0d] m1", a), h1.rd_data, exp);
  endtask

  typedef struct {
    int           za;
    logic [31:0]  b;
    logic [127:0] key;
    int           extra_k;
    logic [1:0]   ex_done;
    logic [1:0]   ex_err;
    int           ex_ce;
    bit           sweep;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int za;
    int sel;
    logic [1:0] edone;
    logic [1:0] eerr;
    logic [127:0] rkey;
    logic [31:0] rbase;

    vecs[0] = '{20, 32'h1000_0000, KEY_NOM, 0,  2'b11, 2'b00, 20, 1'b1};
    vecs[1] = '{12, 32'h2000_0000, KEY_NOM, 0,  2'b00, 2'b11, 12, 1'b0};
    vecs[2] = '{20, 32'h1000_0000, KEY_NOM, 0,  2'b11, 2'b00, 20, 1'b0};
    vecs[3] = '{63, 32'h3000_0000, KEY_NOM, 0,  2'b10, 2'b01, 20, 1'b0};
    vecs[4] = '{20, 32'h1000_0000, KEY_NOM, 10, 2'b11, 2'b00, 20, 1'b1};
    vecs[5] = '{20, 32'h4000_0000, 128'h0123456789abcdef0011223344556677, 23, 2'b11, 2'b00, 20, 1'b0};
    vecs[6] = '{0,  32'h5000_0000, 128'hffeeddccbbaa99887766554433221100, 0, 2'b00, 2'b11, 0, 1'b0};

    reset = 1'b1;
    drive_start(1'b0, '0);
    h0.rd_addr = '0;
    h1.rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", {h0.busy, h1.busy}, 2'b00);
    chk("rst done", {h0.done, h1.done}, 2'b00);
    chk("rst err", {h0.err, h1.err}, 2'b00);
    chk("rst valid", {h0.keys_valid, h1.keys_valid}, 2'b00);
    chk("rst rd_data", {h0.rd_data, h1.rd_data}, 64'h0);
    chk("rst sg_key", sg_key[0] | sg_key[1], 128'h0);
    chk("rst sg_ce", {sg_ce[0], sg_ce[1]}, 2'b00);
    chk("rst sg_reset", {sg_reset[0], sg_reset[1]}, 2'b11);
    reset = 1'b0;
    @(negedge clk);
    chk("idle sg_reset", {sg_reset[0], sg_reset[1]}, 2'b00);

    for (int i = 0; i < 7; i++) begin
      run_sched(vecs[i].za, vecs[i].b, vecs[i].key, vecs[i].extra_k,
                ~vecs[i].key, vecs[i].ex_done, vecs[i].ex_err, vecs[i].ex_ce,
                $sformatf("vec%0d", i));
      if (vecs[i].sweep) begin
        for (int a = 0; a < NW; a++) read_word(a);
        read_word(40);
        read_word(63);
      end
    end

    // Reset mid-run; same generator base as the file holds, so contents stay known.
    zero_at = 20;
    base    = 32'h4000_0000;
    @(negedge clk);
    drive_start(1'b1, KEY_NOM);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) drive_start(1'b0, KEY_NOM);
      if (k == 7) reset = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy", {h0.busy, h1.busy}, 2'b00);
    chk("midrst sg_ce", {sg_ce[0], sg_ce[1]}, 2'b00);
    chk("midrst sg_reset", {sg_reset[0], sg_reset[1]}, 2'b11);
    chk("midrst valid", {h0.keys_valid, h1.keys_valid}, 2'b00);
    chk("midrst done", {h0.done, h1.done}, 2'b00);
    chk("midrst err", {h0.err, h1.err}, 2'b00);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    for (int a = 0; a < 4; a++) read_word(a * 11);

    // Randomized schedules against the outcome rules of the reference model.
    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       za = $urandom_range(0, NPAIRS - 1);
        1:       za = NPAIRS;
        default: za = $urandom_range(NPAIRS + 1, 63);
      endcase
      rbase = {$urandom_range(1, 255), 24'h0};
      rkey  = {$urandom, $urandom, $urandom, $urandom};
      for (int m = 0; m < 2; m++) begin
        edone[m] = (za == NPAIRS) || (za > NPAIRS && m == 1);
        eerr[m]  = ~edone[m];
      end
      run_sched(za, rbase, rkey, 0, '0, edone, eerr,
                (za < NPAIRS) ? za : NPAIRS, $sformatf("rnd%0d", r));
      for (int j = 0; j < 5; j++) read_word($urandom_range(0, 63));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
